adc_line_capture: RTL and testbench

- Upstream write-side sequencer for the ping-pong line buffer.
- Takes qualified ADC samples from the sensor front end, frames them into rows of PIX_IN_ROW pixels and drives the buffer's write enable, write data and bank select.
- Hands each completed row to the downstream readout through a LINE_READY / READ_DONE handshake.
- Detects rows that complete while the readout still owns the other bank, drops them and flags overflow.

---
 rtl/adc_line_capture_if.sv | 30 +++
 rtl/adc_line_capture.sv | 160 ++++++++++++++++
 tb/tb_adc_line_capture.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_line_capture_if.sv
// Port bundle between the ADC front end / readout and the line-capture sequencer.
// master: the side that supplies samples and handshakes; slave: the capture block.
interface adc_line_capture_if #(
    parameter int unsigned ADC_WIDHT = 14,
    parameter int unsigned ROW_W     = 8
);
    logic                 ENABLE;
    logic                 FRAME_SYNC;
    logic                 ADC_VALID;
    logic [ADC_WIDHT-1:0] DATA_IN;
    logic                 READ_DONE;
    logic                 OVF_CLR;
    logic                 BUFER_IN_EN;
    logic                 BUFER_CHANGE;
    logic [ADC_WIDHT-1:0] DATA_OUT;
    logic                 LINE_READY;
    logic [ROW_W-1:0]     ROW_NUM;
    logic                 FRAME_DONE;
    logic                 OVERFLOW;

    modport master (
        output ENABLE, FRAME_SYNC, ADC_VALID, DATA_IN, READ_DONE, OVF_CLR,
        input  BUFER_IN_EN, BUFER_CHANGE, DATA_OUT, LINE_READY, ROW_NUM, FRAME_DONE, OVERFLOW
    );

    modport slave (
        input  ENABLE, FRAME_SYNC, ADC_VALID, DATA_IN, READ_DONE, OVF_CLR,
        output BUFER_IN_EN, BUFER_CHANGE, DATA_OUT, LINE_READY, ROW_NUM, FRAME_DONE, OVERFLOW
    );
endinterface

// File: rtl/adc_line_capture.sv
// Write-side sequencer for the ping-pong line buffer: frames ADC samples into rows,
// drives the buffer write port and bank select, hands completed rows to the readout
// and drops rows that complete while the readout still owns the other bank.
module adc_line_capture #(
    parameter int unsigned ADC_WIDHT    = 14,
    parameter int unsigned PIX_IN_ROW   = 160,
    parameter int unsigned ROW_IN_FRAME = 120,
    parameter int unsigned ROW_W        = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    adc_line_capture_if.slave   bus
);

    localparam int unsigned PIX_W = (PIX_IN_ROW > 1) ? $clog2(PIX_IN_ROW) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_IN_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_IN_FRAME - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitFrame,
        StCapture
    } state_t;

    state_t               state_q, state_d;
    logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [ROW_W-1:0]     row_num_q, row_num_d;
    logic                 busy_q, busy_d;
    logic                 bufer_change_q, bufer_change_d;
    logic [ADC_WIDHT-1:0] data_out_q, data_out_d;
    logic                 wr_en_q, wr_en_d;
    logic                 line_ready_q, line_ready_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overflow_q, overflow_d;
    // A handed-over row swaps banks one edge late so its last pixel still
    // lands in the bank the readout is about to own.
    logic                 swap_pend_q, swap_pend_d;

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q        <= StIdle;
            pix_cnt_q      <= '0;
            row_num_q      <= '0;
            busy_q         <= 1'b0;
            bufer_change_q <= 1'b1;
            data_out_q     <= '0;
            wr_en_q        <= 1'b0;
            line_ready_q   <= 1'b0;
            frame_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
            swap_pend_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            row_num_q      <= row_num_d;
            busy_q         <= busy_d;
            bufer_change_q <= bufer_change_d;
            data_out_q     <= data_out_d;
            wr_en_q        <= wr_en_d;
            line_ready_q   <= line_ready_d;
            frame_done_q   <= frame_done_d;
            overflow_q     <= overflow_d;
            swap_pend_q    <= swap_pend_d;
        end
    end

    // Next-state: FSM, pixel/row counters, handshake and overflow bookkeeping.
    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        row_num_d      = row_num_q;
        busy_d         = busy_q;
        bufer_change_d = bufer_change_q;
        data_out_d     = data_out_q;
        wr_en_d        = 1'b0;
        line_ready_d   = 1'b0;
        frame_done_d   = 1'b0;
        overflow_d     = overflow_q;
        swap_pend_d    = 1'b0;

        if (bus.OVF_CLR) begin
            overflow_d = 1'b0;
        end
        // Readout releases its bank; harmless when nothing is outstanding.
        if (bus.READ_DONE) begin
            busy_d = 1'b0;
        end
        // Finish a hand-over decided on the previous edge, whatever the state.
        if (swap_pend_q) begin
            bufer_change_d = ~bufer_change_q;
            line_ready_d   = 1'b1;
        end

        if (!bus.ENABLE) begin
            // Partial row discarded; busy and bank select deliberately kept.
            state_d   = StIdle;
            pix_cnt_d = '0;
            row_num_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWaitFrame;
                end
                StWaitFrame: begin
                    if (bus.FRAME_SYNC) begin
                        state_d   = StCapture;
                        pix_cnt_d = '0;
                        row_num_d = '0;
                    end
                end
                StCapture: begin
                    if (bus.FRAME_SYNC) begin
                        // Restart the frame; beats a completing sample on the same edge.
                        pix_cnt_d = '0;
                        row_num_d = '0;
                    end else if (bus.ADC_VALID) begin
                        data_out_d = bus.DATA_IN;
                        wr_en_d    = 1'b1;
                        if (pix_cnt_q == PIX_LAST) begin
                            pix_cnt_d = '0;
                            if (!busy_q || bus.READ_DONE) begin
                                // Coinciding READ_DONE is consumed here, so busy stays set.
                                swap_pend_d = 1'b1;
                                busy_d      = 1'b1;
                            end else begin
                                // Readout still owns the other bank: drop and rewrite this one.
                                overflow_d = 1'b1;
                            end
                            if (row_num_q == ROW_LAST) begin
                                row_num_d    = '0;
                                frame_done_d = 1'b1;
                                state_d      = StWaitFrame;
                            end else begin
                                row_num_d = row_num_q + ROW_W'(1);
                            end
                        end else begin
                            pix_cnt_d = pix_cnt_q + PIX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Registered outputs onto the interface.
    always_comb begin
        bus.BUFER_IN_EN  = wr_en_q;
        bus.BUFER_CHANGE = bufer_change_q;
        bus.DATA_OUT     = data_out_q;
        bus.LINE_READY   = line_ready_q;
        bus.ROW_NUM      = row_num_q;
        bus.FRAME_DONE   = frame_done_q;
        bus.OVERFLOW     = overflow_q;
    end

endmodule

// File: tb/tb_adc_line_capture.sv
// Directed bench for adc_line_capture with 4-pixel rows and 3-row frames.
module tb_adc_line_capture;

    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    adc_line_capture_if #(.ADC_WIDHT(14), .ROW_W(8)) bus ();

    adc_line_capture #(
        .ADC_WIDHT   (14),
        .PIX_IN_ROW  (4),
        .ROW_IN_FRAME(3),
        .ROW_W       (8)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of sequence, required $finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Apply one cycle of inputs, then release the pulse inputs.
    task automatic drive(input logic v, input logic [13:0] d, input logic fs, input logic rd);
        bus.ADC_VALID  = v;
        bus.DATA_IN    = d;
        bus.FRAME_SYNC = fs;
        bus.READ_DONE  = rd;
        tick();
        bus.ADC_VALID  = 1'b0;
        bus.FRAME_SYNC = 1'b0;
        bus.READ_DONE  = 1'b0;
    endtask

    // n consecutive samples base, base+1, ...; optional READ_DONE with the last one.
    task automatic feed(input int n, input logic [13:0] base, input logic rd_last);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 14'(i), 1'b0, rd_last && (i == n - 1));
            chk("wr_en", 32'(bus.BUFER_IN_EN), 32'd1);
            chk("wr_data", 32'(bus.DATA_OUT), 32'(base + 14'(i)));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},   32'(bus.BUFER_IN_EN), 32'd0);
        chk({tag, "_chg"},  32'(bus.BUFER_CHANGE), 32'd1);
        chk({tag, "_dout"}, 32'(bus.DATA_OUT), 32'd0);
        chk({tag, "_lr"},   32'(bus.LINE_READY), 32'd0);
        chk({tag, "_row"},  32'(bus.ROW_NUM), 32'd0);
        chk({tag, "_fd"},   32'(bus.FRAME_DONE), 32'd0);
        chk({tag, "_ovf"},  32'(bus.OVERFLOW), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RESET = 1'b0;
        bus.ENABLE     = 1'b0;
        bus.FRAME_SYNC = 1'b0;
        bus.ADC_VALID  = 1'b0;
        bus.DATA_IN    = '0;
        bus.READ_DONE  = 1'b0;
        bus.OVF_CLR    = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        RESET = 1'b1;

        // First row: hand-over with bank swap one edge after the last strobe.
        bus.ENABLE = 1'b1;
        tick();
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        chk("fs_row", 32'(bus.ROW_NUM), 32'd0);
        chk("fs_en", 32'(bus.BUFER_IN_EN), 32'd0);
        feed(4, 14'h100, 1'b0);
        chk("r0_chg_old", 32'(bus.BUFER_CHANGE), 32'd1);
        chk("r0_lr_early", 32'(bus.LINE_READY), 32'd0);
        chk("r0_row", 32'(bus.ROW_NUM), 32'd1);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("r0_en_off", 32'(bus.BUFER_IN_EN), 32'd0);
        chk("r0_chg_new", 32'(bus.BUFER_CHANGE), 32'd0);
        chk("r0_lr", 32'(bus.LINE_READY), 32'd1);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("r0_lr_once", 32'(bus.LINE_READY), 32'd0);
        chk("r0_dout_hold", 32'(bus.DATA_OUT), 32'h103);

        // Row 1 completes while busy: dropped.
        feed(4, 14'h200, 1'b0);
        chk("drop_ovf", 32'(bus.OVERFLOW), 32'd1);
        chk("drop_row", 32'(bus.ROW_NUM), 32'd2);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("drop_chg", 32'(bus.BUFER_CHANGE), 32'd0);
        chk("drop_lr", 32'(bus.LINE_READY), 32'd0);
        bus.OVF_CLR = 1'b1;
        tick();
        bus.OVF_CLR = 1'b0;
        chk("ovf_clr", 32'(bus.OVERFLOW), 32'd0);

        // Row 2 (last of frame) with READ_DONE on its last sample: swap, busy kept.
        feed(4, 14'h210, 1'b1);
        chk("f0_fd", 32'(bus.FRAME_DONE), 32'd1);
        chk("f0_row", 32'(bus.ROW_NUM), 32'd0);
        chk("f0_ovf", 32'(bus.OVERFLOW), 32'd0);
        chk("f0_chg_old", 32'(bus.BUFER_CHANGE), 32'd0);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("f0_chg_new", 32'(bus.BUFER_CHANGE), 32'd1);
        chk("f0_lr", 32'(bus.LINE_READY), 32'd1);
        chk("f0_fd_once", 32'(bus.FRAME_DONE), 32'd0);

        // Busy still set: next row drops; OVF_CLR on the same edge loses to the set.
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        feed(3, 14'h300, 1'b0);
        bus.OVF_CLR = 1'b1;
        drive(1'b1, 14'h303, 1'b0, 1'b0);
        bus.OVF_CLR = 1'b0;
        chk("setwins_ovf", 32'(bus.OVERFLOW), 32'd1);
        chk("setwins_row", 32'(bus.ROW_NUM), 32'd1);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("setwins_chg", 32'(bus.BUFER_CHANGE), 32'd1);
        chk("setwins_lr", 32'(bus.LINE_READY), 32'd0);
        bus.OVF_CLR = 1'b1;
        tick();
        bus.OVF_CLR = 1'b0;
        chk("ovf_clr2", 32'(bus.OVERFLOW), 32'd0);

        // Full frame with READ_DONE after each hand-over: banks 0,1,0.
        drive(1'b0, 14'h0, 1'b0, 1'b1);
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        chk("abort_row", 32'(bus.ROW_NUM), 32'd0);
        feed(4, 14'h400, 1'b0);
        chk("fa_row1", 32'(bus.ROW_NUM), 32'd1);
        chk("fa_fd_r0", 32'(bus.FRAME_DONE), 32'd0);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("fa_chg0", 32'(bus.BUFER_CHANGE), 32'd0);
        chk("fa_lr0", 32'(bus.LINE_READY), 32'd1);
        drive(1'b0, 14'h0, 1'b0, 1'b1);
        feed(4, 14'h404, 1'b0);
        chk("fa_row2", 32'(bus.ROW_NUM), 32'd2);
        chk("fa_fd_r1", 32'(bus.FRAME_DONE), 32'd0);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("fa_chg1", 32'(bus.BUFER_CHANGE), 32'd1);
        chk("fa_lr1", 32'(bus.LINE_READY), 32'd1);
        drive(1'b0, 14'h0, 1'b0, 1'b1);
        feed(4, 14'h408, 1'b0);
        chk("fa_fd", 32'(bus.FRAME_DONE), 32'd1);
        chk("fa_row_wrap", 32'(bus.ROW_NUM), 32'd0);
        chk("fa_ovf", 32'(bus.OVERFLOW), 32'd0);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("fa_chg2", 32'(bus.BUFER_CHANGE), 32'd0);
        chk("fa_lr2", 32'(bus.LINE_READY), 32'd1);
        chk("fa_fd_once", 32'(bus.FRAME_DONE), 32'd0);
        drive(1'b0, 14'h0, 1'b0, 1'b1);
        drive(1'b1, 14'h3ff, 1'b0, 1'b0);
        chk("wf_ignore_en", 32'(bus.BUFER_IN_EN), 32'd0);
        chk("wf_ignore_dout", 32'(bus.DATA_OUT), 32'h40b);

        // FRAME_SYNC mid-row aborts without a hand-over.
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        feed(4, 14'h500, 1'b0);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("ab_chg_a", 32'(bus.BUFER_CHANGE), 32'd1);
        drive(1'b0, 14'h0, 1'b0, 1'b1);
        feed(2, 14'h510, 1'b0);
        chk("ab_row_before", 32'(bus.ROW_NUM), 32'd1);
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        chk("ab_row", 32'(bus.ROW_NUM), 32'd0);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("ab_lr", 32'(bus.LINE_READY), 32'd0);
        chk("ab_chg", 32'(bus.BUFER_CHANGE), 32'd1);
        feed(4, 14'h520, 1'b0);
        chk("ab_next_row", 32'(bus.ROW_NUM), 32'd1);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("ab_next_lr", 32'(bus.LINE_READY), 32'd1);
        chk("ab_next_chg", 32'(bus.BUFER_CHANGE), 32'd0);
        drive(1'b0, 14'h0, 1'b0, 1'b1);

        // FRAME_SYNC on the completing sample's edge: row discarded.
        feed(3, 14'h530, 1'b0);
        drive(1'b1, 14'h533, 1'b1, 1'b0);
        chk("fsw_en", 32'(bus.BUFER_IN_EN), 32'd0);
        chk("fsw_dout", 32'(bus.DATA_OUT), 32'h532);
        chk("fsw_row", 32'(bus.ROW_NUM), 32'd0);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("fsw_lr", 32'(bus.LINE_READY), 32'd0);
        chk("fsw_chg", 32'(bus.BUFER_CHANGE), 32'd0);

        // Reset after 3 pixels.
        feed(3, 14'h600, 1'b0);
        RESET = 1'b0;
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk_reset_vals("midrst");
        RESET = 1'b1;
        drive(1'b1, 14'h6aa, 1'b0, 1'b0);
        chk("postrst_en", 32'(bus.BUFER_IN_EN), 32'd0);
        chk("postrst_lr", 32'(bus.LINE_READY), 32'd0);
        chk("postrst_dout", 32'(bus.DATA_OUT), 32'd0);

        // ENABLE low after 3 pixels: back to IDLE, partial row discarded.
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        feed(3, 14'h700, 1'b0);
        bus.ENABLE = 1'b0;
        drive(1'b1, 14'h7ff, 1'b0, 1'b0);
        chk("dis_en", 32'(bus.BUFER_IN_EN), 32'd0);
        chk("dis_row", 32'(bus.ROW_NUM), 32'd0);
        chk("dis_dout", 32'(bus.DATA_OUT), 32'h702);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("dis_lr", 32'(bus.LINE_READY), 32'd0);
        bus.ENABLE = 1'b1;
        drive(1'b1, 14'h7fe, 1'b0, 1'b0);
        chk("reen_ignore", 32'(bus.BUFER_IN_EN), 32'd0);
        drive(1'b0, 14'h0, 1'b1, 1'b0);
        feed(1, 14'h710, 1'b0);
        chk("reen_row_a", 32'(bus.ROW_NUM), 32'd0);
        feed(3, 14'h711, 1'b0);
        chk("reen_row_b", 32'(bus.ROW_NUM), 32'd1);
        chk("reen_chg_old", 32'(bus.BUFER_CHANGE), 32'd1);
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        chk("reen_lr", 32'(bus.LINE_READY), 32'd1);
        chk("reen_chg", 32'(bus.BUFER_CHANGE), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
